// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Bundles the fetch, data and memory-side signals of the shared
//            memory-port arbiter. The slave modport is the arbiter's view;
//            the master modport is the view of the surrounding pipeline
//            and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_valid;
  logic [DATA_W-1:0]     if_rdata;
  // Load/store data requester
  logic                  d_req;
  logic                  d_wr;
  logic [DATA_W/8-1:0]   d_mask;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_done;
  logic [DATA_W-1:0]     d_rdata;
  // Shared memory port
  logic                  mem_req;
  logic                  mem_wr;
  logic [DATA_W/8-1:0]   mem_mask;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;
  // Pipeline stalls
  logic                  stall_f;
  logic                  stall_m;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_wr, d_mask, d_addr, d_wdata,
    input  mem_ack, mem_rdata,
    output if_valid, if_rdata,
    output d_done, d_rdata,
    output mem_req, mem_wr, mem_mask, mem_addr, mem_wdata,
    output stall_f, stall_m
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_wr, d_mask, d_addr, d_wdata,
    output mem_ack, mem_rdata,
    input  if_valid, if_rdata,
    input  d_done, d_rdata,
    input  mem_req, mem_wr, mem_mask, mem_addr, mem_wdata,
    input  stall_f, stall_m
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and the
//            load/store unit. Data wins by fixed priority, but after
//            STARVE_LIMIT consecutive data grants taken while fetch waits,
//            fetch is forced through. Drives pipeline stalls while an
//            access is outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int              c_mask_w     = DATA_W / 8;
  localparam logic [3:0]      c_starve_max = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_mem_req;
  logic                  r_mem_wr;
  logic [c_mask_w-1:0]   r_mem_mask;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [3:0]            r_starve_cnt;

  logic                  w_mem_req_nxt;
  logic                  w_mem_wr_nxt;
  logic [c_mask_w-1:0]   w_mem_mask_nxt;
  logic [ADDR_W-1:0]     w_mem_addr_nxt;
  logic [DATA_W-1:0]     w_mem_wdata_nxt;
  logic [3:0]            w_starve_cnt_nxt;

  logic                  w_data_wins;
  logic                  w_if_valid;
  logic                  w_d_done;

  // Data wins unless fetch is waiting and has already been passed over too often.
  assign w_data_wins = bus.d_req && (!bus.if_req || (r_starve_cnt < c_starve_max));

  // Next-state and next memory-command computation; memory fields only change on a grant.
  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_wr_nxt     = r_mem_wr;
    w_mem_mask_nxt   = r_mem_mask;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_starve_cnt_nxt = r_starve_cnt;

    case (r_state)
      IDLE: begin
        if (w_data_wins) begin
          w_state_nxt     = BUSY_D;
          w_mem_req_nxt   = 1'b1;
          w_mem_wr_nxt    = bus.d_wr;
          w_mem_mask_nxt  = bus.d_mask;
          w_mem_addr_nxt  = bus.d_addr;
          w_mem_wdata_nxt = bus.d_wdata;
          if (bus.if_req && (r_starve_cnt < c_starve_max)) begin
            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
          end
        end else if (bus.if_req) begin
          w_state_nxt      = BUSY_I;
          w_mem_req_nxt    = 1'b1;
          w_mem_wr_nxt     = 1'b0;
          w_mem_mask_nxt   = {c_mask_w{1'b1}};
          w_mem_addr_nxt   = bus.if_addr;
          w_mem_wdata_nxt  = '0;
          w_starve_cnt_nxt = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        // The IDLE cycle that follows is the mandatory turnaround.
        if (bus.mem_ack) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and registered memory command; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_mask   <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_mem_mask   <= w_mem_mask_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // Completions are qualified by the busy state so an ack seen in IDLE is dropped.
  assign w_if_valid = (r_state == BUSY_I) && bus.mem_ack;
  assign w_d_done   = (r_state == BUSY_D) && bus.mem_ack;

  assign bus.if_valid  = w_if_valid;
  assign bus.d_done    = w_d_done;
  assign bus.if_rdata  = w_if_valid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (w_d_done && !r_mem_wr) ? bus.mem_rdata : '0;

  assign bus.stall_f   = bus.if_req && !w_if_valid;
  assign bus.stall_m   = bus.d_req && !w_d_done;

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_mask  = r_mem_mask;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter: directed scenarios
//            plus a randomized run against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  string gs;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_mask = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  // Acks every access one cycle after mem_req rises and records grant order as D/I.
  task automatic run_grants(input int n);
    int   cycles;
    int   cnt;
    logic prev;
    cycles = 0; cnt = 0; prev = 0; gs = "";
    while (cnt < n && cycles < 100) begin
      next_cycle();
      if (bus.mem_req && !prev) begin
        cnt++;
        gs = {gs, (bus.mem_addr == bus.d_addr) ? "D" : "I"};
      end
      bus.mem_ack = bus.mem_req;
      prev = bus.mem_req;
      cycles++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
    #1;
    tests++;
    if ({bus.mem_req, bus.mem_wr, bus.mem_mask} !== 6'd0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 000000", {bus.mem_req, bus.mem_wr, bus.mem_mask});
    end
    tests++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin
      fails++; $display("FAIL reset_addr_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata});
    end
    tests++;
    if ({bus.if_valid, bus.d_done, bus.stall_f, bus.stall_m, bus.if_rdata, bus.d_rdata} !== 68'd0) begin
      fails++; $display("FAIL reset_comb: got %h expected 0",
                        {bus.if_valid, bus.d_done, bus.stall_f, bus.stall_m, bus.if_rdata, bus.d_rdata});
    end
  endtask

  task automatic test_single_fetch();
    next_cycle();
    bus.if_req = 1; bus.if_addr = 32'h10;
    #1;
    tests++;
    if (bus.stall_f !== 1'b1) begin fails++; $display("FAIL fetch_stall_req: got %b expected 1", bus.stall_f); end
    next_cycle();
    tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h10}) begin
      fails++; $display("FAIL fetch_grant: got req=%b addr=%h expected req=1 addr=10", bus.mem_req, bus.mem_addr);
    end
    tests++;
    if ({bus.mem_wr, bus.mem_mask, bus.mem_wdata} !== {1'b0, 4'hf, 32'h0}) begin
      fails++; $display("FAIL fetch_cmd: got wr=%b mask=%h wdata=%h expected 0 f 0", bus.mem_wr, bus.mem_mask, bus.mem_wdata);
    end
    next_cycle();
    tests++;
    if ({bus.stall_f, bus.if_valid} !== 2'b10) begin
      fails++; $display("FAIL fetch_wait: got stall_f=%b if_valid=%b expected 1 0", bus.stall_f, bus.if_valid);
    end
    next_cycle();
    bus.mem_ack = 1; bus.mem_rdata = 32'h00500093;
    #1;
    tests++;
    if ({bus.if_valid, bus.stall_f, bus.if_rdata} !== {1'b1, 1'b0, 32'h00500093}) begin
      fails++; $display("FAIL fetch_done: got v=%b stall=%b rdata=%h expected 1 0 00500093", bus.if_valid, bus.stall_f, bus.if_rdata);
    end
    next_cycle();
    bus.mem_ack = 0; bus.if_req = 0; bus.mem_rdata = '0;
    #1;
    tests++;
    if ({bus.mem_req, bus.if_valid} !== 2'b00) begin
      fails++; $display("FAIL fetch_turnaround: got req=%b v=%b expected 0 0", bus.mem_req, bus.if_valid);
    end
  endtask

  task automatic test_simultaneous();
    next_cycle();
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.d_req = 1; bus.d_wr = 0; bus.d_mask = 4'hf; bus.d_addr = 32'h200; bus.d_wdata = '0;
    next_cycle();
    tests++;
    if ({bus.mem_req, bus.mem_wr, bus.mem_addr} !== {2'b10, 32'h200}) begin
      fails++; $display("FAIL sim_data_first: got req=%b wr=%b addr=%h expected 1 0 200", bus.mem_req, bus.mem_wr, bus.mem_addr);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'h11223344;
    #1;
    tests++;
    if ({bus.d_done, bus.if_valid, bus.stall_m, bus.stall_f, bus.d_rdata} !== {4'b1001, 32'h11223344}) begin
      fails++; $display("FAIL sim_data_done: got dd=%b iv=%b sm=%b sf=%b rdata=%h expected 1 0 0 1 11223344",
                        bus.d_done, bus.if_valid, bus.stall_m, bus.stall_f, bus.d_rdata);
    end
    next_cycle();
    bus.mem_ack = 0; bus.d_req = 0;
    tests++;
    if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL sim_turnaround: got req=%b expected 0", bus.mem_req); end
    next_cycle();
    tests++;
    if ({bus.mem_req, bus.mem_wr, bus.mem_mask, bus.mem_addr, bus.mem_wdata} !== {2'b10, 4'hf, 32'h40, 32'h0}) begin
      fails++; $display("FAIL sim_fetch_second: got req=%b wr=%b mask=%h addr=%h expected 1 0 f 40",
                        bus.mem_req, bus.mem_wr, bus.mem_mask, bus.mem_addr);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE0001;
    #1;
    tests++;
    if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'hCAFE0001}) begin
      fails++; $display("FAIL sim_fetch_done: got v=%b rdata=%h expected 1 cafe0001", bus.if_valid, bus.if_rdata);
    end
    next_cycle();
    bus.mem_ack = 0; bus.if_req = 0;
  endtask

  task automatic test_store();
    next_cycle();
    bus.d_req = 1; bus.d_wr = 1; bus.d_mask = 4'b0011; bus.d_addr = 32'h100; bus.d_wdata = 32'h0000ABCD;
    next_cycle();
    tests++;
    if ({bus.mem_req, bus.mem_wr, bus.mem_mask, bus.mem_addr, bus.mem_wdata} !== {2'b11, 4'b0011, 32'h100, 32'h0000ABCD}) begin
      fails++; $display("FAIL store_cmd: got req=%b wr=%b mask=%b addr=%h wdata=%h expected 1 1 0011 100 0000abcd",
                        bus.mem_req, bus.mem_wr, bus.mem_mask, bus.mem_addr, bus.mem_wdata);
    end
    #1;
    tests++;
    if ({bus.d_done, bus.stall_m} !== 2'b01) begin
      fails++; $display("FAIL store_wait: got dd=%b sm=%b expected 0 1", bus.d_done, bus.stall_m);
    end
    next_cycle();
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
    #1;
    tests++;
    if ({bus.d_done, bus.stall_m, bus.d_rdata} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL store_done: got dd=%b sm=%b rdata=%h expected 1 0 0", bus.d_done, bus.stall_m, bus.d_rdata);
    end
    next_cycle();
    bus.mem_ack = 0; bus.d_req = 0; bus.d_wr = 0;
    tests++;
    if ({bus.mem_req, bus.mem_wr, bus.mem_addr} !== {2'b01, 32'h100}) begin
      fails++; $display("FAIL store_hold: got req=%b wr=%b addr=%h expected 0 1 100", bus.mem_req, bus.mem_wr, bus.mem_addr);
    end
  endtask

  task automatic test_starvation();
    next_cycle();
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h300; bus.d_mask = 4'hf;
    bus.if_req = 1; bus.if_addr = 32'h80;
    run_grants(6);
    tests++;
    if (gs != "DDIDDI") begin fails++; $display("FAIL starve_order: got %s expected DDIDDI", gs); end
    next_cycle();
    bus.mem_ack = 0; bus.d_req = 0; bus.if_req = 0;
  endtask

  task automatic test_reset_mid();
    next_cycle();
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h180; bus.if_req = 1; bus.if_addr = 32'h84;
    next_cycle();
    tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h180}) begin
      fails++; $display("FAIL rstmid_grant: got req=%b addr=%h expected 1 180", bus.mem_req, bus.mem_addr);
    end
    rst = 1; bus.d_req = 0; bus.if_req = 0;
    next_cycle();
    rst = 0;
    tests++;
    if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rstmid_req: got %b expected 0", bus.mem_req); end
    next_cycle();
    bus.mem_ack = 1; bus.mem_rdata = 32'h55AA55AA;
    #1;
    tests++;
    if ({bus.d_done, bus.if_valid, bus.d_rdata} !== 34'd0) begin
      fails++; $display("FAIL rstmid_late_ack: got dd=%b iv=%b rdata=%h expected 0 0 0", bus.d_done, bus.if_valid, bus.d_rdata);
    end
    next_cycle();
    bus.mem_ack = 0;
    tests++;
    if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got req=%b expected 0", bus.mem_req); end
    // A cleared starvation count lets data win twice before fetch is forced.
    bus.d_req = 1; bus.d_addr = 32'h300; bus.if_req = 1; bus.if_addr = 32'h80;
    run_grants(3);
    tests++;
    if (gs != "DDI") begin fails++; $display("FAIL rstmid_starve_clear: got %s expected DDI", gs); end
    next_cycle();
    bus.mem_ack = 0; bus.d_req = 0; bus.if_req = 0;
  endtask

  task automatic test_spurious();
    next_cycle();
    bus.mem_ack = 1; bus.mem_rdata = $urandom;
    #1;
    tests++;
    if ({bus.if_valid, bus.d_done, bus.if_rdata, bus.d_rdata} !== 66'd0) begin
      fails++; $display("FAIL spurious_comb: got iv=%b dd=%b expected 0 0", bus.if_valid, bus.d_done);
    end
    next_cycle();
    bus.mem_ack = 0;
    tests++;
    if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL spurious_req: got %b expected 0", bus.mem_req); end
  endtask

  // Transaction-level model: requesters hold a request until served, memory answers
  // after a random latency, grants follow data priority bounded by the starvation rule.
  task automatic test_random();
    logic        i_act, d_act, busy, own_d, ack;
    int          cnt, lat;
    logic [31:0] e_addr, e_wdata, rd, exp_ir, exp_dr;
    logic        e_wr, exp_iv, exp_dd;
    logic [3:0]  e_mask;
    i_act = 0; d_act = 0; busy = 0; own_d = 0; cnt = 0; lat = 0;
    e_addr = '0; e_wdata = '0; e_wr = 0; e_mask = '0;
    next_cycle();
    clear_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
    for (int c = 0; c < 800; c++) begin
      next_cycle();
      tests++;
      if (bus.mem_req !== busy) begin
        fails++; $display("FAIL rnd_req c=%0d: got %b expected %b", c, bus.mem_req, busy);
      end
      if (busy) begin
        tests++;
        if ({bus.mem_addr, bus.mem_wr, bus.mem_mask, bus.mem_wdata} !== {e_addr, e_wr, e_mask, e_wdata}) begin
          fails++; $display("FAIL rnd_cmd c=%0d: got %h/%b/%h/%h expected %h/%b/%h/%h", c,
                            bus.mem_addr, bus.mem_wr, bus.mem_mask, bus.mem_wdata, e_addr, e_wr, e_mask, e_wdata);
        end
      end
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; bus.if_addr = $urandom;
      end
      if (!d_act && $urandom_range(0, 1) == 0) begin
        d_act = 1; bus.d_wr = 1'($urandom_range(0, 1)); bus.d_mask = 4'($urandom);
        bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
      bus.if_req = i_act; bus.d_req = d_act;
      if (busy) begin
        ack = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        ack = ($urandom_range(0, 7) == 0);
      end
      rd = $urandom;
      bus.mem_ack = ack; bus.mem_rdata = rd;
      #1;
      exp_iv = busy && ack && !own_d;
      exp_dd = busy && ack && own_d;
      exp_ir = exp_iv ? rd : 32'h0;
      exp_dr = (exp_dd && !e_wr) ? rd : 32'h0;
      tests++;
      if ({bus.if_valid, bus.d_done, bus.if_rdata, bus.d_rdata} !== {exp_iv, exp_dd, exp_ir, exp_dr}) begin
        fails++; $display("FAIL rnd_done c=%0d: got %b%b %h %h expected %b%b %h %h", c,
                          bus.if_valid, bus.d_done, bus.if_rdata, bus.d_rdata, exp_iv, exp_dd, exp_ir, exp_dr);
      end
      tests++;
      if ({bus.stall_f, bus.stall_m} !== {i_act && !exp_iv, d_act && !exp_dd}) begin
        fails++; $display("FAIL rnd_stall c=%0d: got %b%b expected %b%b", c,
                          bus.stall_f, bus.stall_m, i_act && !exp_iv, d_act && !exp_dd);
      end
      if (busy) begin
        if (ack) begin
          busy = 0;
          if (own_d) d_act = 0; else i_act = 0;
        end
      end else if (d_act && (!i_act || cnt < STARVE_LIMIT)) begin
        busy = 1; own_d = 1; lat = $urandom_range(0, 3);
        e_addr = bus.d_addr; e_wr = bus.d_wr; e_mask = bus.d_mask; e_wdata = bus.d_wdata;
        if (i_act) cnt = (cnt < STARVE_LIMIT) ? cnt + 1 : STARVE_LIMIT;
      end else if (i_act) begin
        busy = 1; own_d = 0; lat = $urandom_range(0, 3);
        e_addr = bus.if_addr; e_wr = 0; e_mask = 4'hf; e_wdata = '0;
        cnt = 0;
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_starvation();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
